// File: rtl/lm_event_queue.sv
// Event queue feeding an LED decoder: a circular buffer of event codes, each
// popped code is presented for HOLD_CYCLES clocks, back-to-back when more wait.
module lm_event_queue #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  input  logic                   clear_overflow,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic [HW-1:0]    hold_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  logic full_s;
  logic hold_last_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign full_s      = (count_q == CW'(DEPTH));
  assign hold_last_s = (hold_q == HW'(HOLD_CYCLES - 1));

  // Pop/push decisions and next-state of the occupancy count and sticky flag
  always_comb begin
    pop_s = 1'b0;
    if (count_q != {CW{1'b0}}) begin
      case (state_q)
        ST_IDLE: pop_s = 1'b1;
        ST_SHOW: pop_s = hold_last_s;
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end

    // A full queue still accepts a write when the same edge frees a slot.
    push_s = wr_valid && (!full_s || pop_s);
    drop_s = wr_valid && !push_s;

    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    overflow_d = overflow_q;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Entry storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Queue pointers, occupancy and overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Presentation FSM with registered outputs and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= {HW{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hold_q <= {HW{1'b0}};
          if (pop_s) begin
            out_data_q  <= mem_q[rd_ptr_q];
            out_valid_q <= 1'b1;
            state_q     <= ST_SHOW;
          end else begin
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (hold_last_s) begin
            hold_q <= {HW{1'b0}};
            if (pop_s) begin
              out_data_q  <= mem_q[rd_ptr_q];
              out_valid_q <= 1'b1;
            end else begin
              out_data_q  <= {WIDTH{1'b0}};
              out_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          hold_q      <= {HW{1'b0}};
          out_data_q  <= {WIDTH{1'b0}};
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_lm_event_queue.sv
// Randomized and directed bench for lm_event_queue against a queue-based model
// that tracks the presented event as a remaining-cycles countdown.
module tb_lm_event_queue;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] wr_data = 4'h0;
  logic             wr_valid = 1'b0;
  logic             clear_overflow = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [2:0]       count;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  int mq[$];
  bit m_show  = 1'b0;
  int m_left  = 0;
  int m_cur   = 0;
  bit m_ovf   = 1'b0;
  bit m_ready = 1'b0;

  lm_event_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .clear_overflow(clear_overflow), .out_data(out_data), .out_valid(out_valid),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input int dut_v, input int mdl_v, input int lit);
    chk({name, "_dut"}, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  function automatic int m_data();
    return m_show ? m_cur : 0;
  endfunction

  // Reference model: advance one clock per rising edge, clear on reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_show  = 1'b0;
      m_left  = 0;
      m_cur   = 0;
      m_ovf   = 1'b0;
      m_ready = 1'b1;
    end else begin
      bit pop;
      bit acc;
      pop = (mq.size() != 0) && (!m_show || m_left == 1);
      acc = wr_valid && (mq.size() < DEPTH || pop);
      if (pop) begin
        m_cur  = mq.pop_front();
        m_show = 1'b1;
        m_left = HOLD;
      end else if (m_show) begin
        if (m_left == 1) begin
          m_show = 1'b0;
          m_cur  = 0;
        end else begin
          m_left--;
        end
      end
      if (acc) mq.push_back(int'(wr_data));
      if (wr_valid && !acc) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
    end
    #1;
    if (m_ready) begin
      chk("cyc_out_valid", int'(out_valid), int'(m_show));
      chk("cyc_out_data", int'(out_data), m_data());
      chk("cyc_count", int'(count), mq.size());
      chk("cyc_overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    wr_valid = v;
    wr_data = d;
    clear_overflow = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen[$];
    int last;
    bit pv;
    int pd;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    pin("rst_valid", int'(out_valid), int'(m_show), 0);
    pin("rst_data", int'(out_data), m_data(), 0);
    pin("rst_count", int'(count), mq.size(), 0);
    pin("rst_ovf", int'(overflow), int'(m_ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // single event
    step(1'b1, 4'h5, 1'b0);
    pin("single_cnt_e1", int'(count), mq.size(), 1);
    pin("single_vld_e1", int'(out_valid), int'(m_show), 0);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 4'h0, 1'b0);
      pin("single_vld_hold", int'(out_valid), int'(m_show), 1);
      pin("single_data_hold", int'(out_data), m_data(), 5);
    end
    step(1'b0, 4'h0, 1'b0);
    pin("single_vld_e6", int'(out_valid), int'(m_show), 0);
    pin("single_data_e6", int'(out_data), m_data(), 0);

    // back-to-back: 1,2,3 each held 4 cycles with no gap
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    pin("b2b_data_e2", int'(out_data), m_data(), 1);
    step(1'b1, 4'h3, 1'b0);
    for (int e = 4; e <= 14; e++) begin
      step(1'b0, 4'h0, 1'b0);
      if (e == 6) pin("b2b_data_e6", int'(out_data), m_data(), 2);
      if (e == 9) pin("b2b_data_e9", int'(out_data), m_data(), 2);
      if (e == 10) pin("b2b_data_e10", int'(out_data), m_data(), 3);
      if (e == 13) pin("b2b_data_e13", int'(out_data), m_data(), 3);
    end
    pin("b2b_vld_e14", int'(out_valid), int'(m_show), 0);

    // overflow: fill while showing, then a write with no pop is dropped
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    pin("ovf_full_e5", int'(count), mq.size(), 4);
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    pin("ovf_full_e7", int'(count), mq.size(), 4);
    step(1'b1, 4'hA, 1'b0);
    pin("ovf_set", int'(overflow), int'(m_ovf), 1);
    pin("ovf_count", int'(count), mq.size(), 4);
    step(1'b0, 4'h0, 1'b1);
    pin("ovf_clear", int'(overflow), int'(m_ovf), 0);

    // full plus pop: write lands on an end-of-hold pop
    step(1'b1, 4'hB, 1'b0);
    pin("fullpop_count", int'(count), mq.size(), 4);
    pin("fullpop_ovf", int'(overflow), int'(m_ovf), 0);
    pin("fullpop_data", int'(out_data), m_data(), 3);
    last = -1;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 4'h0, 1'b0);
      if (!out_valid) break;
      last = int'(out_data);
    end
    chk("fullpop_drained", int'(out_valid), 0);
    chk("fullpop_last", last, 11);

    // pointer wrap: ten distinct codes in write order
    pv = 1'b0;
    pd = -1;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < HOLD; s++) begin
        step((s == 0) ? 1'b1 : 1'b0, 4'(i), 1'b0);
        if (out_valid && (!pv || int'(out_data) != pd)) seen.push_back(int'(out_data));
        pv = out_valid;
        pd = int'(out_data);
      end
    end
    for (int s = 0; s < 12; s++) begin
      step(1'b0, 4'h0, 1'b0);
      if (out_valid && (!pv || int'(out_data) != pd)) seen.push_back(int'(out_data));
      pv = out_valid;
      pd = int'(out_data);
    end
    chk("wrap_count", seen.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_order", (i < seen.size()) ? seen[i] : -1, i);
    end

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    // reset mid-show with two entries queued
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b0;
    clear_overflow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    pin("rstmid_pre_count", int'(count), mq.size(), 2);
    pin("rstmid_pre_vld", int'(out_valid), int'(m_show), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    #2;
    rst = 1'b1;
    #2;
    pin("rstmid_vld", int'(out_valid), int'(m_show), 0);
    pin("rstmid_data", int'(out_data), m_data(), 0);
    pin("rstmid_count", int'(count), mq.size(), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b1;
    wr_data = 4'h7;
    @(posedge clk);
    #2;
    pin("rstmid_new_cnt", int'(count), mq.size(), 1);
    step(1'b0, 4'h0, 1'b0);
    pin("rstmid_new_vld", int'(out_valid), int'(m_show), 1);
    pin("rstmid_new_data", int'(out_data), m_data(), 7);
    repeat (3) step(1'b0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lm_event_queue.md
LM_EVENT_QUEUE -- requirements
Module: lm_event_queue

Interface
REQ-001 Parameter WIDTH, default 4: bit width of one event code.
REQ-002 Parameter DEPTH, default 8: number of queue entries; power of two, minimum 2.
REQ-003 Parameter HOLD_CYCLES, default 50000000: number of clk cycles each event is presented downstream; minimum 1.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port wr_data, input, WIDTH: event code from a producer (UART or CM).
REQ-007 Port wr_valid, input, 1: one-cycle write strobe for wr_data.
REQ-008 Port clear_overflow, input, 1: synchronous clear of the overflow flag.
REQ-009 Port out_data, output, WIDTH: event code currently presented to the LED decoder.
REQ-010 Port out_valid, output, 1: out_data holds a live event.
REQ-011 Port count, output, $clog2(DEPTH)+1: number of entries stored, excluding the one being presented.
REQ-012 Port overflow, output, 1: sticky flag; set when a write is dropped.

Function
REQ-013 Storage is a circular buffer with write and read pointers of $clog2(DEPTH) bits; both pointers wrap from DEPTH-1 to 0.
REQ-014 Full condition: count==DEPTH. Empty condition: count==0.
REQ-015 A write with wr_valid=1 when not full stores wr_data at wr_ptr, increments wr_ptr, and increments count.
REQ-016 A write when full is accepted only if a pop occurs in the same cycle; otherwise it is dropped, and overflow is set on the next edge.
REQ-017 On a simultaneous accepted write and pop, count is unchanged.
REQ-018 clear_overflow=1 clears overflow on the next edge; if a drop occurs in the same cycle, set wins.
REQ-019 The state machine has two states: IDLE and SHOW.
REQ-020 IDLE behaviour:
- out_valid=0 and out_data=0.
- If count!=0, pop: out_data<=mem[rd_ptr], rd_ptr++, count--, hold counter<=0, go to SHOW.
REQ-021 SHOW behaviour:
- out_valid=1 and out_data is held stable.
- The hold counter increments each cycle, counting 0..HOLD_CYCLES-1.
REQ-022 SHOW exit when the hold counter reaches HOLD_CYCLES-1:
- If count!=0, pop the next entry, restart the counter at 0, and stay in SHOW (back-to-back, no idle cycle).
- Otherwise go to IDLE; out_valid=0 and out_data=0 from the next cycle.
REQ-023 Each popped event is presented for exactly HOLD_CYCLES cycles.
REQ-024 Latency: a write at edge N into an empty queue with FSM in IDLE gives out_valid=1 from edge N+1 (pop on the following edge).
REQ-025 The hold counter is wide enough for HOLD_CYCLES-1 and never wraps past it.
REQ-026 Writes are accepted in every state, independent of the FSM.
REQ-027 Outputs count, out_valid, out_data and overflow are driven from registers; there is no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 forces, without waiting for a clock edge:
- state=IDLE, out_valid=0, out_data=0;
- wr_ptr=0, rd_ptr=0, count=0, overflow=0, hold counter=0.
REQ-029 Memory contents need not be reset; no stale entry becomes visible after reset because count=0.
REQ-030 Reset asserted mid-SHOW abandons the presented event and every queued event.
REQ-031 Deassertion of rst is synchronized externally; the first write is accepted on the first edge after deassertion.

Verification (bench parameters: WIDTH=4, DEPTH=4, HOLD_CYCLES=4)
REQ-032 Single event:
- Stimulus: write 0x5 at edge 1.
- Response: count=1 after edge 1; out_valid=1 and out_data=0x5 after edge 2 for exactly 4 cycles; out_valid=0 and out_data=0 after edge 6.
REQ-033 Back-to-back:
- Stimulus: write 0x1, 0x2, 0x3 on consecutive edges.
- Response: out_data presents 0x1, 0x2, 0x3 for 4 cycles each with no idle gap; then out_valid=0.
REQ-034 Overflow:
- Stimulus: hold the FSM in SHOW, fill to count=4, then write 0xA with no pop.
- Response: write dropped, overflow=1, count stays 4.
- Stimulus: pulse clear_overflow.
- Response: overflow=0.
REQ-035 Full plus pop:
- Stimulus: count=4, then write 0xB in the same cycle as an end-of-hold pop.
- Response: write accepted, count stays 4, overflow stays 0, 0xB is presented last.
REQ-036 Pointer wrap:
- Stimulus: stream 10 distinct codes, 0x0 to 0x9, spaced to avoid overflow.
- Response: all 10 presented in write order across pointer wrap-around.
REQ-037 Reset mid-operation:
- Stimulus: assert rst during SHOW with count=2, asynchronously between clock edges.
- Response: out_valid=0, out_data=0, count=0 immediately; after release, a new write 0x7 is presented after 2 edges.
